// File: rtl/ibex_csr_ctrl_pkg.sv
// rtl/ibex_csr_ctrl_pkg.sv - shared types and constants for the CSR bank write controller
package ibex_csr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    CHECK   = 2'd2,
    SETBACK = 2'd3
  } csr_ctrl_state_e;

  typedef logic csr_req_id_t;

  localparam csr_req_id_t ReqIdCore  = 1'b0;
  localparam csr_req_id_t ReqIdDebug = 1'b1;

endpackage

// File: rtl/ibex_csr_rr_arb.sv
// rtl/ibex_csr_rr_arb.sv - 2-way round-robin arbiter, pointer names the requester favoured next
module ibex_csr_rr_arb
  import ibex_csr_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req,
  input  logic        advance,
  output logic [1:0]  gnt,
  output csr_req_id_t gnt_id
);

  csr_req_id_t ptr_q;
  csr_req_id_t ptr_other;

  // The requester that is not currently favoured
  always_comb begin
    ptr_other = (ptr_q == ReqIdCore) ? ReqIdDebug : ReqIdCore;
  end

  // Favoured requester wins if it asks, otherwise the other one gets a chance
  always_comb begin
    gnt_id         = req[ptr_q] ? ptr_q : ptr_other;
    gnt            = '0;
    gnt[gnt_id]    = req[gnt_id];
  end

  // After a grant, favour whoever did not just win
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= ReqIdCore;
    end else if (advance) begin
      ptr_q <= (gnt_id == ReqIdCore) ? ReqIdDebug : ReqIdCore;
    end
  end

endmodule

// File: rtl/ibex_csr_bank_ctrl.sv
// rtl/ibex_csr_bank_ctrl.sv - CSR bank write sequencer/arbiter with integrity alert; IBEX_CSR_SCRUB_EN adds background scrub
module ibex_csr_bank_ctrl
  import ibex_csr_ctrl_pkg::*;
#(
  parameter int NumCsr      = 4,
  parameter int Width       = 32,
  parameter int AddrW       = 3,
  parameter int ScrubPeriod = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_i,
  input  logic [1:0][AddrW-1:0]      addr_i,
  input  logic [1:0][Width-1:0]      wdata_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 done_o,
  output logic                       err_o,
  input  logic                       setback_req_i,
  output logic                       setback_ack_o,
  output logic [NumCsr-1:0]          csr_wr_en_o,
  output logic [Width-1:0]           csr_wr_data_o,
  output logic                       csr_setback_o,
  input  logic [NumCsr-1:0]          csr_rd_error_i,
  output logic                       alert_o
);

  csr_ctrl_state_e state_q, state_d;

  logic [AddrW-1:0] addr_q;
  logic [Width-1:0] data_q;
  csr_req_id_t      id_q;

  logic [1:0]       arb_gnt;
  csr_req_id_t      arb_id;
  logic             arb_advance;

  logic             addr_hit;
  logic             sel_err;
  logic             chk_fail;
  logic             scrub_fail;
  logic             alert_q;

  ibex_csr_rr_arb u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_i),
    .advance (arb_advance),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id)
  );

  // Decode the latched address against the bank; a miss marks a bad address
  always_comb begin
    addr_hit = 1'b0;
    sel_err  = 1'b0;
    for (int i = 0; i < NumCsr; i++) begin
      if (addr_q == AddrW'(i)) begin
        addr_hit = 1'b1;
        sel_err  = csr_rd_error_i[i];
      end
    end
  end

  // Next-state and output decode; setback always wins over a new write in IDLE
  always_comb begin
    state_d       = state_q;
    gnt_o         = '0;
    done_o        = '0;
    err_o         = 1'b0;
    setback_ack_o = 1'b0;
    csr_setback_o = 1'b0;
    csr_wr_en_o   = '0;
    csr_wr_data_o = '0;
    arb_advance   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setback_req_i) begin
          state_d = SETBACK;
        end else if (|req_i) begin
          gnt_o       = arb_gnt;
          arb_advance = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        for (int i = 0; i < NumCsr; i++) begin
          csr_wr_en_o[i] = (addr_q == AddrW'(i));
        end
        csr_wr_data_o = data_q;
        state_d       = CHECK;
      end
      CHECK: begin
        done_o[id_q] = 1'b1;
        err_o        = ~addr_hit | sel_err;
        state_d      = IDLE;
      end
      SETBACK: begin
        csr_setback_o = 1'b1;
        setback_ack_o = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning requester's transaction on the grant cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      id_q   <= ReqIdCore;
    end else if (arb_advance) begin
      addr_q <= addr_i[arb_id];
      data_q <= wdata_i[arb_id];
      id_q   <= arb_id;
    end
  end

  // Only a genuine shadow mismatch raises the alert, not a bad address
  always_comb begin
    chk_fail = (state_q == CHECK) && addr_hit && sel_err;
  end

`ifdef IBEX_CSR_SCRUB_EN
  localparam int CntW = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;
  localparam int IdxW = $clog2(NumCsr);

  logic [CntW-1:0] scrub_cnt_q;
  logic [IdxW-1:0] scrub_idx_q;
  logic            scrub_fire;
  logic            scrub_err;

  // Fire once per ScrubPeriod cycles and pick up the flag of the current index
  always_comb begin
    scrub_fire = (scrub_cnt_q == CntW'(ScrubPeriod - 1));
    scrub_err  = 1'b0;
    for (int i = 0; i < NumCsr; i++) begin
      if (scrub_idx_q == IdxW'(i)) begin
        scrub_err = csr_rd_error_i[i];
      end
    end
    scrub_fail = scrub_fire && scrub_err && (state_q != WRITE) && (state_q != SETBACK);
  end

  // Free-running period counter and index walk; skipped fires still advance the index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scrub_cnt_q <= '0;
      scrub_idx_q <= '0;
    end else begin
      scrub_cnt_q <= scrub_fire ? '0 : scrub_cnt_q + CntW'(1);
      if (scrub_fire) begin
        scrub_idx_q <= (scrub_idx_q == IdxW'(NumCsr - 1)) ? '0 : scrub_idx_q + IdxW'(1);
      end
    end
  end
`else
  logic unused_scrub_cfg;

  assign scrub_fail       = 1'b0;
  assign unused_scrub_cfg = (ScrubPeriod < 2);
`endif

  // Sticky alert, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alert_q <= 1'b0;
    end else if (chk_fail || scrub_fail) begin
      alert_q <= 1'b1;
    end
  end

  assign alert_o = alert_q;

endmodule

// File: tb/tb_ibex_csr_bank_ctrl.sv
// tb/tb_ibex_csr_bank_ctrl.sv - randomized self-checking bench for ibex_csr_bank_ctrl
module tb_ibex_csr_bank_ctrl;

  localparam int NumCsr      = 4;
  localparam int Width       = 32;
  localparam int AddrW       = 3;
  localparam int ScrubPeriod = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [1:0]            req_i = '0;
  logic [1:0][AddrW-1:0] addr_i = '0;
  logic [1:0][Width-1:0] wdata_i = '0;
  logic [1:0]            gnt_o;
  logic [1:0]            done_o;
  logic                  err_o;
  logic                  setback_req_i = 1'b0;
  logic                  setback_ack_o;
  logic [NumCsr-1:0]     csr_wr_en_o;
  logic [Width-1:0]      csr_wr_data_o;
  logic                  csr_setback_o;
  logic [NumCsr-1:0]     csr_rd_error_i = '0;
  logic                  alert_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: who is favoured next, and whether an alert is owed
  int   pref = 0;
  logic model_alert = 1'b0;

  // Observations captured by run_write
  logic [1:0]        obs_gnt, obs_done;
  logic [NumCsr-1:0] obs_en;
  logic [Width-1:0]  obs_data;
  logic              obs_err, obs_alert, obs_alert_chk;

  // Expectations produced by model_txn
  logic [1:0]        exp_gnt, exp_done;
  logic [NumCsr-1:0] exp_en;
  logic [Width-1:0]  exp_data;
  logic              exp_err, exp_bad;

  always #5 clk_i = ~clk_i;

  ibex_csr_bank_ctrl #(
    .NumCsr      (NumCsr),
    .Width       (Width),
    .AddrW       (AddrW),
    .ScrubPeriod (ScrubPeriod)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .setback_req_i  (setback_req_i),
    .setback_ack_o  (setback_ack_o),
    .csr_wr_en_o    (csr_wr_en_o),
    .csr_wr_data_o  (csr_wr_data_o),
    .csr_setback_o  (csr_setback_o),
    .csr_rd_error_i (csr_rd_error_i),
    .alert_o        (alert_o)
  );

  task automatic apply_reset();
    @(posedge clk_i); #1;
    rst_ni         = 1'b0;
    req_i          = '0;
    addr_i         = '0;
    wdata_i        = '0;
    setback_req_i  = 1'b0;
    csr_rd_error_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    pref        = 0;
    model_alert = 1'b0;
  endtask

  // Round-robin rule and write semantics applied to one transaction
  task automatic model_txn(input logic [1:0] req, input logic [AddrW-1:0] a0, input logic [AddrW-1:0] a1,
                           input logic [Width-1:0] d0, input logic [Width-1:0] d1, input logic [NumCsr-1:0] inj);
    int w, a;
    logic hit_err;
    w        = req[pref] ? pref : 1 - pref;
    a        = (w == 1) ? int'(a1) : int'(a0);
    exp_gnt  = 2'(1 << w);
    exp_done = 2'(1 << w);
    exp_bad  = (a >= NumCsr);
    exp_en   = exp_bad ? '0 : NumCsr'(1 << a);
    exp_data = (w == 1) ? d1 : d0;
    hit_err  = exp_bad ? 1'b0 : inj[a];
    exp_err  = exp_bad || hit_err;
    if (hit_err) model_alert = 1'b1;
    pref = 1 - w;
  endtask

  // Drives one request through grant, write and check phases, capturing outputs
  task automatic run_write(input logic [1:0] req, input logic [AddrW-1:0] a0, input logic [AddrW-1:0] a1,
                           input logic [Width-1:0] d0, input logic [Width-1:0] d1, input logic [NumCsr-1:0] inj);
    @(posedge clk_i); #1;
    req_i = req; addr_i[0] = a0; addr_i[1] = a1; wdata_i[0] = d0; wdata_i[1] = d1;
    @(negedge clk_i);
    obs_gnt = gnt_o;
    @(posedge clk_i); #1;
    req_i = '0;
    @(negedge clk_i);
    obs_en = csr_wr_en_o; obs_data = csr_wr_data_o;
    @(posedge clk_i); #1;
    csr_rd_error_i = inj;
    @(negedge clk_i);
    obs_done = done_o; obs_err = err_o; obs_alert_chk = alert_o;
    @(posedge clk_i); #1;
    csr_rd_error_i = '0;
    obs_alert = alert_o;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
    checks++; if (done_o !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done_o); end
    checks++; if (alert_o !== 1'b0) begin errors++; $display("FAIL reset_alert: got %b want 0", alert_o); end
    apply_reset();
    @(negedge clk_i);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (setback_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", setback_ack_o); end
    checks++; if (csr_setback_o !== 1'b0) begin errors++; $display("FAIL reset_setback: got %b want 0", csr_setback_o); end
    checks++; if (csr_wr_en_o !== '0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", csr_wr_en_o); end
    checks++; if (csr_wr_data_o !== '0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", csr_wr_data_o); end
  endtask

  task automatic test_single_write();
    apply_reset();
    model_txn(2'b01, 3'd2, 3'd0, 32'hDEADBEEF, 32'h0, '0);
    run_write(2'b01, 3'd2, 3'd0, 32'hDEADBEEF, 32'h0, '0);
    checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", obs_gnt); end
    checks++; if (obs_en !== 4'b0100) begin errors++; $display("FAIL single_en: got %b want 0100", obs_en); end
    checks++; if (obs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", obs_data); end
    checks++; if (obs_done !== 2'b01) begin errors++; $display("FAIL single_done: got %b want 01", obs_done); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", obs_err); end
    checks++; if (obs_alert !== 1'b0) begin errors++; $display("FAIL single_alert: got %b want 0", obs_alert); end
  endtask

  task automatic test_both_held();
    logic [1:0]        g_log [18];
    logic [1:0]        d_log [18];
    logic [NumCsr-1:0] e_log [18];
    logic [Width-1:0]  w_log [18];
    logic              r_log [18];
    logic [Width-1:0]  d0, d1;
    int w, a;
    apply_reset();
    d0 = $urandom; d1 = $urandom;
    @(posedge clk_i); #1;
    req_i = 2'b11; addr_i[0] = 3'd1; addr_i[1] = 3'd3; wdata_i[0] = d0; wdata_i[1] = d1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_i);
      g_log[c] = gnt_o; d_log[c] = done_o; e_log[c] = csr_wr_en_o; w_log[c] = csr_wr_data_o; r_log[c] = err_o;
    end
    @(posedge clk_i); #1;
    req_i = '0;
    for (int k = 0; k < 6; k++) begin
      w = pref;
      pref = 1 - w;
      a = (w == 1) ? 3 : 1;
      checks++; if (g_log[3*k] !== 2'(1 << w)) begin errors++; $display("FAIL held_gnt[%0d]: got %b want %b", k, g_log[3*k], 2'(1 << w)); end
      checks++; if (g_log[3*k+1] !== 2'b00 || g_log[3*k+2] !== 2'b00) begin errors++; $display("FAIL held_gap[%0d]: got %b %b want 00 00", k, g_log[3*k+1], g_log[3*k+2]); end
      checks++; if (e_log[3*k+1] !== NumCsr'(1 << a)) begin errors++; $display("FAIL held_en[%0d]: got %b want %b", k, e_log[3*k+1], NumCsr'(1 << a)); end
      checks++; if (w_log[3*k+1] !== ((w == 1) ? d1 : d0)) begin errors++; $display("FAIL held_data[%0d]: got %h want %h", k, w_log[3*k+1], (w == 1) ? d1 : d0); end
      checks++; if (d_log[3*k+2] !== 2'(1 << w) || r_log[3*k+2] !== 1'b0) begin errors++; $display("FAIL held_done[%0d]: got %b/%b want %b/0", k, d_log[3*k+2], r_log[3*k+2], 2'(1 << w)); end
    end
  endtask

  task automatic test_bad_addr();
    logic [Width-1:0] d1;
    d1 = $urandom;
    model_txn(2'b10, 3'd0, 3'd5, 32'h0, d1, '0);
    run_write(2'b10, 3'd0, 3'd5, 32'h0, d1, '0);
    checks++; if (obs_gnt !== 2'b10) begin errors++; $display("FAIL bad_gnt: got %b want 10", obs_gnt); end
    checks++; if (obs_en !== 4'b0000) begin errors++; $display("FAIL bad_en: got %b want 0000", obs_en); end
    checks++; if (obs_done !== 2'b10) begin errors++; $display("FAIL bad_done: got %b want 10", obs_done); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b want 1", obs_err); end
    checks++; if (obs_alert !== 1'b0) begin errors++; $display("FAIL bad_alert: got %b want 0", obs_alert); end
  endtask

  task automatic test_setback();
    logic [Width-1:0] d0;
    d0 = $urandom;
    @(posedge clk_i); #1;
    setback_req_i = 1'b1; req_i = 2'b01; addr_i[0] = 3'd3; wdata_i[0] = d0;
    @(negedge clk_i);
    checks++; if (gnt_o !== 2'b00 || csr_setback_o !== 1'b0) begin errors++; $display("FAIL sb_idle: got gnt %b sb %b want 00 0", gnt_o, csr_setback_o); end
    @(negedge clk_i);
    checks++; if (csr_setback_o !== 1'b1 || setback_ack_o !== 1'b1 || gnt_o !== 2'b00) begin errors++; $display("FAIL sb_pulse: got sb %b ack %b gnt %b want 1 1 00", csr_setback_o, setback_ack_o, gnt_o); end
    @(posedge clk_i); #1;
    setback_req_i = 1'b0;
    model_txn(2'b01, 3'd3, 3'd0, d0, 32'h0, '0);
    @(negedge clk_i);
    checks++; if (gnt_o !== exp_gnt || csr_setback_o !== 1'b0) begin errors++; $display("FAIL sb_after_gnt: got gnt %b sb %b want %b 0", gnt_o, csr_setback_o, exp_gnt); end
    @(posedge clk_i); #1;
    req_i = '0; setback_req_i = 1'b1;
    @(negedge clk_i);
    checks++; if (csr_wr_en_o !== exp_en || csr_setback_o !== 1'b0) begin errors++; $display("FAIL sb_held_write: got en %b sb %b want %b 0", csr_wr_en_o, csr_setback_o, exp_en); end
    @(negedge clk_i);
    checks++; if (done_o !== exp_done || csr_setback_o !== 1'b0) begin errors++; $display("FAIL sb_held_check: got done %b sb %b want %b 0", done_o, csr_setback_o, exp_done); end
    @(negedge clk_i);
    checks++; if (csr_setback_o !== 1'b0 || gnt_o !== 2'b00) begin errors++; $display("FAIL sb_late_idle: got sb %b gnt %b want 0 00", csr_setback_o, gnt_o); end
    @(negedge clk_i);
    checks++; if (csr_setback_o !== 1'b1 || setback_ack_o !== 1'b1) begin errors++; $display("FAIL sb_late_pulse: got sb %b ack %b want 1 1", csr_setback_o, setback_ack_o); end
    @(posedge clk_i); #1;
    setback_req_i = 1'b0;
    @(negedge clk_i);
    checks++; if (csr_setback_o !== 1'b0 || setback_ack_o !== 1'b0) begin errors++; $display("FAIL sb_one_cycle: got sb %b ack %b want 0 0", csr_setback_o, setback_ack_o); end
  endtask

  task automatic test_random_writes();
    logic [1:0]       req;
    logic [AddrW-1:0] a0, a1;
    logic [Width-1:0] d0, d1;
    for (int n = 0; n < 24; n++) begin
      req = 2'($urandom_range(1, 3));
      a0 = AddrW'($urandom_range(0, 7)); a1 = AddrW'($urandom_range(0, 7));
      d0 = $urandom; d1 = $urandom;
      model_txn(req, a0, a1, d0, d1, '0);
      run_write(req, a0, a1, d0, d1, '0);
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, obs_gnt, exp_gnt); end
      checks++; if (obs_en !== exp_en) begin errors++; $display("FAIL rnd_en[%0d]: got %b want %b", n, obs_en, exp_en); end
      if (!exp_bad) begin
        checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, obs_data, exp_data); end
      end
      checks++; if (obs_done !== exp_done || obs_err !== exp_err) begin errors++; $display("FAIL rnd_done[%0d]: got %b/%b want %b/%b", n, obs_done, obs_err, exp_done, exp_err); end
      checks++; if (obs_alert !== model_alert) begin errors++; $display("FAIL rnd_alert[%0d]: got %b want %b", n, obs_alert, model_alert); end
    end
  endtask

  task automatic test_alert();
    logic [Width-1:0] d;
    apply_reset();
    d = $urandom;
    model_txn(2'b01, 3'd2, 3'd0, d, 32'h0, 4'b0100);
    run_write(2'b01, 3'd2, 3'd0, d, 32'h0, 4'b0100);
    checks++; if (obs_done !== 2'b01 || obs_err !== 1'b1) begin errors++; $display("FAIL alert_err: got %b/%b want 01/1", obs_done, obs_err); end
    checks++; if (obs_alert_chk !== 1'b0) begin errors++; $display("FAIL alert_early: got %b want 0", obs_alert_chk); end
    checks++; if (obs_alert !== model_alert) begin errors++; $display("FAIL alert_set: got %b want %b", obs_alert, model_alert); end
    d = $urandom;
    model_txn(2'b10, 3'd0, 3'd0, 32'h0, d, '0);
    run_write(2'b10, 3'd0, 3'd0, 32'h0, d, '0);
    checks++; if (obs_err !== exp_err || obs_alert !== model_alert) begin errors++; $display("FAIL alert_sticky: got err %b alert %b want %b %b", obs_err, obs_alert, exp_err, model_alert); end
    apply_reset();
    @(negedge clk_i);
    checks++; if (alert_o !== 1'b0) begin errors++; $display("FAIL alert_clear: got %b want 0", alert_o); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    @(posedge clk_i); #1;
    req_i = 2'b01; addr_i[0] = 3'd3; wdata_i[0] = $urandom;
    @(negedge clk_i);
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL mid_gnt: got %b want 01", gnt_o); end
    @(posedge clk_i); #1;
    req_i = '0; rst_ni = 1'b0;
    #1;
    checks++; if (csr_wr_en_o !== '0) begin errors++; $display("FAIL mid_wr_en: got %b want 0", csr_wr_en_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1; pref = 0; model_alert = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o !== 2'b00) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b want 0", saw_done); end
    model_txn(2'b11, 3'd0, 3'd1, 32'h1, 32'h2, '0);
    run_write(2'b11, 3'd0, 3'd1, 32'h1, 32'h2, '0);
    checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL mid_ptr_reset: got %b want %b", obs_gnt, exp_gnt); end
  endtask

  task automatic test_scrub();
    logic seen, want;
    apply_reset();
    csr_rd_error_i = 4'b0010;
    seen = 1'b0;
`ifdef IBEX_CSR_SCRUB_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    for (int c = 0; c < 4 * NumCsr + 2 && !seen; c++) begin
      @(negedge clk_i);
      if (alert_o === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== want) begin errors++; $display("FAIL scrub_alert: got %b want %b", seen, want); end
    csr_rd_error_i = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_both_held();
    test_bad_addr();
    test_setback();
    test_random_writes();
    test_alert();
    test_reset_mid();
    test_scrub();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_csr_bank_ctrl.md
# ibex_csr_bank_ctrl

Write sequencer and arbiter for a bank of `NumCsr` shadowed CSR primitives in the Ibex core. Two requesters share the single write path into the bank: requester 0 is the core pipeline and requester 1 is the debug/external port. The block round-robins write grants between them and checks the shadow integrity of each written register one cycle after the write. It also sequences bank-wide setback and raises a sticky alert on any integrity failure.

## Interface
Parameters:
- `NumCsr`, 4: number of CSR primitives in the bank (≥2).
- `Width`, 32: CSR data width.
- `AddrW`, 3: address width; must satisfy 2^AddrW ≥ NumCsr.
- `ScrubPeriod`, 16: cycles between background scrub checks (scrub build only; ≥2).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  2  write request per requester.
- `addr_i`  in  2×AddrW  target CSR index per requester.
- `wdata_i`  in  2×Width  write data per requester.
- `gnt_o`  out  2  grant, one-hot or zero.
- `done_o`  out  2  completion pulse per requester.
- `err_o`  out  1  error qualifier, valid only when a `done_o` bit is high.
- `setback_req_i`  in  1  request bank-wide setback.
- `setback_ack_o`  out  1  one-cycle pulse when setback completes.
- `csr_wr_en_o`  out  NumCsr  one-hot write enable to the bank.
- `csr_wr_data_o`  out  Width  write data to the bank.
- `csr_setback_o`  out  1  setback strobe to all CSRs.
- `csr_rd_error_i`  in  NumCsr  shadow mismatch flags from the bank.
- `alert_o`  out  1  sticky integrity alert.

## Operation
- FSM states: IDLE, WRITE, CHECK, SETBACK. The reset state is IDLE.
- IDLE transitions:
  - If `setback_req_i` is high, go to SETBACK. Setback beats pending writes, and no grant is issued that cycle.
  - Else if any `req_i` bit is high, the arbiter picks a winner and `gnt_o[winner]` goes high combinationally. Address, data and requester ID are registered, then go to WRITE.
- Arbitration is 2-way round-robin:
  - Priority goes to the requester that was not granted last.
  - The pointer resets to favour requester 0.
  - The pointer updates only on a grant.
- WRITE:
  - If the registered address is < NumCsr, drive `csr_wr_en_o[addr]`=1 and `csr_wr_data_o`=registered data.
  - If the address is out of range, all enables stay 0 and the transaction is flagged as a bad address.
  - Always go to CHECK.
- CHECK:
  - Pulse `done_o[id]`=1 with `err_o` = (bad address) OR `csr_rd_error_i[addr]`.
  - If that was a real shadow mismatch (not a bad address), set `alert_o`.
  - Return to IDLE.
- SETBACK: `csr_setback_o`=1 and `setback_ack_o`=1 for exactly one cycle, then return to IDLE.
- A `setback_req_i` that arrives during WRITE or CHECK is held off until IDLE. The requester keeps it high until it sees the ack.
- Requesters keep `req_i`, `addr_i` and `wdata_i` stable until granted. After the grant cycle these inputs are don't-care.
- `alert_o` is cleared only by `rst_ni`.

## Timing
- Reset values: all outputs 0; `csr_wr_data_o`=0; FSM in IDLE; round-robin pointer favours requester 0.
- Write latency:
  - Grant in cycle T.
  - `csr_wr_en_o` in T+1.
  - `done_o`/`err_o` in T+2.
  - Next grant no earlier than T+3.
  - Throughput is one write per 3 cycles.
- Setback latency: requested in IDLE at cycle T gives `csr_setback_o` at T+1 and returns to IDLE at T+2.
- Simultaneous requests: exactly one grant; the other requester waits at least 3 cycles.
- Reset mid-operation: the FSM is forced to IDLE immediately and any in-flight transaction is discarded with no `done_o`.

## Configuration
- Macro: `IBEX_CSR_SCRUB_EN`.
- Defined:
  - A free-running counter fires every `ScrubPeriod` cycles.
  - A scrub index cycles through 0..NumCsr-1 in order, advancing on each fire.
  - When the counter fires, the block samples `csr_rd_error_i[index]` and sets `alert_o` if it is high.
  - Sampling happens in any FSM state except WRITE and SETBACK. A fire that lands in either of those states is skipped and the index still advances.
- Undefined: no counter or index logic; `alert_o` is set only by the post-write CHECK.

## Structure
- Package `ibex_csr_ctrl_pkg` holds:
  - the state enum `csr_ctrl_state_e`;
  - the requester ID typedef `csr_req_id_t`, 1 bit;
  - named constants for the core and debug requester IDs.
- Sub-module `ibex_csr_rr_arb`: 2-way round-robin arbiter.
  - Inputs: `req`, `advance`.
  - Outputs: one-hot `gnt`, `gnt_id`.
  - Contains the pointer flop.

## Test plan
- Requester 0 writes 0xDEADBEEF to addr 2 from IDLE:
  - `gnt_o`=01 at T;
  - `csr_wr_en_o`=0100 with data 0xDEADBEEF at T+1;
  - `done_o`=01 with `err_o`=0 at T+2.
- Both requesters high with addresses 1 and 3, held:
  - grants alternate 01, 10, 01 at 3-cycle spacing, first grant to requester 0 after reset;
  - each `done_o` bit matches its requester.
- Requester 1 writes to addr 5 (out of range, NumCsr=4):
  - `csr_wr_en_o` stays 0;
  - `done_o`=10 with `err_o`=1;
  - `alert_o` stays 0.
- Force `csr_rd_error_i[2]`=1 during CHECK of a write to addr 2: `err_o`=1 and `alert_o`=1 from the next cycle, persisting until reset.
- `setback_req_i` and `req_i`=01 both high in IDLE:
  - no grant;
  - `csr_setback_o` and `setback_ack_o` pulse for 1 cycle;
  - grant to requester 0 follows once `setback_req_i` drops.
- Scrub build with ScrubPeriod=4: hold `csr_rd_error_i[1]`=1 with the bus idle, and `alert_o` rises within 4×NumCsr cycles. Non-scrub build: `alert_o` stays 0.
